// File: rtl/spike_rate_decoder_if.sv
// Spike rate decoder bus: window control, spike inputs and the decoded result.
// The master drives the spike layer / control side, the slave is the decoder.
interface spike_rate_decoder_if #(
    parameter int N_OUTPUT = 3,
    parameter int CNT_W    = 8,
    parameter int WIN_W    = 16
);
    localparam int IDX_W = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;

    logic             spike_in [N_OUTPUT];
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic             abort;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] counts   [N_OUTPUT];
    logic [IDX_W-1:0] winner;
    logic             tie;
    logic             saturated;

    modport master (
        output spike_in, start, window_len, abort, out_ready,
        input  busy, out_valid, counts, winner, tie, saturated
    );

    modport slave (
        input  spike_in, start, window_len, abort, out_ready,
        output busy, out_valid, counts, winner, tie, saturated
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over a programmable window,
// then presents per-channel totals, the winning channel and tie/saturation
// flags until the consumer accepts them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; previous result (counts/winner) held
// S_COUNT  | accumulating spikes, window counter running down to 1
// S_RESULT | result registered; out_valid raised one edge after entry
module spike_rate_decoder #(
    parameter int N_OUTPUT = 3,
    parameter int CNT_W    = 8,
    parameter int WIN_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_rate_decoder_if.slave  bus
);
    localparam int               IDX_W   = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_counts      [N_OUTPUT];
    logic [CNT_W-1:0] w_next_counts [N_OUTPUT];
    logic             r_out_valid;
    logic             r_saturated;
    logic             r_tie;
    logic [IDX_W-1:0] r_winner;

    logic             w_sat_hit;
    logic [CNT_W-1:0] w_max;
    logic [IDX_W-1:0] w_winner;
    logic             w_tie;

    logic             w_accept;
    logic             w_abort;
    logic             w_last;
    logic             w_handshake;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_abort     = (r_state != S_IDLE) && bus.abort;
    assign w_last      = (r_state == S_COUNT) && (r_win_cnt == WIN_W'(1));
    assign w_handshake = (r_state == S_RESULT) && r_out_valid && bus.out_ready;

    // State register; reset discards any window in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort outranks both window completion and handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_COUNT;
                end
            end
            S_COUNT: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (w_handshake) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Saturating per-channel increment; flags any increment lost at the ceiling.
    always_comb begin
        w_sat_hit = 1'b0;
        for (int j = 0; j < N_OUTPUT; j++) begin
            w_next_counts[j] = r_counts[j];
            if (bus.spike_in[j]) begin
                if (r_counts[j] == CNT_MAX) begin
                    w_sat_hit = 1'b1;
                end else begin
                    w_next_counts[j] = r_counts[j] + CNT_W'(1);
                end
            end
        end
    end

    // Arg-max over the post-increment counts so the last cycle's spikes count;
    // strict '>' keeps the lowest index on equal maxima.
    always_comb begin
        w_max    = w_next_counts[0];
        w_winner = '0;
        w_tie    = 1'b0;
        for (int j = 1; j < N_OUTPUT; j++) begin
            if (w_next_counts[j] > w_max) begin
                w_max    = w_next_counts[j];
                w_winner = IDX_W'(j);
                w_tie    = 1'b0;
            end else if (w_next_counts[j] == w_max) begin
                w_tie = 1'b1;
            end
        end
    end

    // Window datapath: counters, window timer, result registers and out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_OUTPUT; j++) begin
                r_counts[j] <= '0;
            end
            r_win_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_saturated <= 1'b0;
            r_tie       <= 1'b0;
            r_winner    <= '0;
        end else if (w_accept) begin
            for (int j = 0; j < N_OUTPUT; j++) begin
                r_counts[j] <= '0;
            end
            // A zero length still gives a one-cycle window.
            r_win_cnt   <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
            r_out_valid <= 1'b0;
            r_saturated <= 1'b0;
            r_tie       <= 1'b0;
            r_winner    <= '0;
        end else if (w_abort) begin
            for (int j = 0; j < N_OUTPUT; j++) begin
                r_counts[j] <= '0;
            end
            r_win_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else if (r_state == S_COUNT) begin
            for (int j = 0; j < N_OUTPUT; j++) begin
                r_counts[j] <= w_next_counts[j];
            end
            if (w_sat_hit) begin
                r_saturated <= 1'b1;
            end
            r_win_cnt <= r_win_cnt - WIN_W'(1);
            if (w_last) begin
                r_winner <= w_winner;
                r_tie    <= w_tie;
            end
        end else if (r_state == S_RESULT) begin
            r_out_valid <= !w_handshake;
        end
    end

    assign bus.busy      = (r_state == S_COUNT) || (r_state == S_RESULT);
    assign bus.out_valid = r_out_valid;
    assign bus.winner    = r_winner;
    assign bus.tie       = r_tie;
    assign bus.saturated = r_saturated;

    for (genvar g = 0; g < N_OUTPUT; g++) begin : g_counts
        assign bus.counts[g] = r_counts[g];
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: table of window patterns with a result
// scoreboard, plus hand-written back-pressure, abort, reset and saturation runs.
module tb_spike_rate_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    spike_rate_decoder_if #(.N_OUTPUT(3), .CNT_W(8), .WIN_W(16)) bus1 ();
    spike_rate_decoder_if #(.N_OUTPUT(3), .CNT_W(4), .WIN_W(16)) bus2 ();

    spike_rate_decoder #(.N_OUTPUT(3), .CNT_W(8), .WIN_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    spike_rate_decoder #(.N_OUTPUT(3), .CNT_W(4), .WIN_W(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Pattern modes: 0 never, 1 every cycle, 2 even cycles, 3 odd cycles.
    typedef struct packed {
        int wl;
        int p0;
        int p1;
        int p2;
        int c0;
        int c1;
        int c2;
        int win;
        int tie;
    } vec_t;

    vec_t vecs [8];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic pat_bit(input int mode, input int k);
        case (mode)
            1:       return 1'b1;
            2:       return (k % 2) == 0;
            3:       return (k % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_spikes1();
        bus1.spike_in[0] = 1'b0;
        bus1.spike_in[1] = 1'b0;
        bus1.spike_in[2] = 1'b0;
    endtask

    // Waits at negedges for out_valid on bus1; returns cycles since start edge.
    task automatic wait_valid1(input int from, input int limit, output int cyc);
        cyc = from;
        while (!bus1.out_valid && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   weff;
        int   cyc;
        vec_t e;
        weff = (v.wl == 0) ? 1 : v.wl;
        @(negedge clk);
        bus1.start      = 1'b1;
        bus1.window_len = 16'(v.wl);
        sb_q.push_back(v);
        @(negedge clk);
        bus1.start = 1'b0;
        check("busy_in_count", bus1.busy, 1);
        for (int k = 0; k < weff; k++) begin
            bus1.spike_in[0] = pat_bit(v.p0, k);
            bus1.spike_in[1] = pat_bit(v.p1, k);
            bus1.spike_in[2] = pat_bit(v.p2, k);
            @(negedge clk);
        end
        clear_spikes1();
        check("busy_in_result", bus1.busy, 1);
        wait_valid1(weff, weff + 10, cyc);
        check("valid_latency", cyc, weff + 1);
        e = sb_q.pop_front();
        if (bus1.out_valid) begin
            check("counts0", bus1.counts[0], e.c0);
            check("counts1", bus1.counts[1], e.c1);
            check("counts2", bus1.counts[2], e.c2);
            check("winner", bus1.winner, e.win);
            check("tie", bus1.tie, e.tie);
            check("saturated", bus1.saturated, 0);
            bus1.out_ready = 1'b1;
            @(negedge clk);
            bus1.out_ready = 1'b0;
            check("idle_busy", bus1.busy, 0);
            check("idle_valid", bus1.out_valid, 0);
            check("hold_counts1", bus1.counts[1], e.c1);
            check("hold_winner", bus1.winner, e.win);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        vec_t v;

        //          wl  p0 p1 p2   c0  c1  c2 win tie
        vecs[0] = '{10, 2, 1, 0,   5, 10,  0,  1,  0};
        vecs[1] = '{ 4, 1, 0, 1,   4,  0,  4,  0,  1};
        vecs[2] = '{ 0, 0, 0, 1,   0,  0,  1,  2,  0};
        vecs[3] = '{ 6, 0, 0, 0,   0,  0,  0,  0,  1};
        vecs[4] = '{ 7, 2, 3, 1,   4,  3,  7,  2,  0};
        vecs[5] = '{ 3, 0, 3, 0,   0,  1,  0,  1,  0};
        vecs[6] = '{ 5, 1, 1, 1,   5,  5,  5,  0,  1};
        vecs[7] = '{ 1, 0, 1, 1,   0,  1,  1,  1,  1};

        clear_spikes1();
        bus1.start = 0; bus1.window_len = 0; bus1.abort = 0; bus1.out_ready = 0;
        bus2.spike_in[0] = 0; bus2.spike_in[1] = 0; bus2.spike_in[2] = 0;
        bus2.start = 0; bus2.window_len = 0; bus2.abort = 0; bus2.out_ready = 0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus1.busy, 0);
        check("rst_valid", bus1.out_valid, 0);
        check("rst_counts0", bus1.counts[0], 0);
        check("rst_counts2", bus1.counts[2], 0);
        check("rst_winner", bus1.winner, 0);
        check("rst_tie", bus1.tie, 0);
        check("rst_saturated", bus1.saturated, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: result held for 5 cycles, start pulses ignored.
        @(negedge clk);
        bus1.start = 1; bus1.window_len = 3;
        @(negedge clk);
        bus1.start = 0; bus1.spike_in[0] = 1;
        repeat (3) @(negedge clk);
        clear_spikes1();
        wait_valid1(3, 13, cyc);
        check("bp_latency", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            bus1.start = (i % 2 == 0);
            @(negedge clk);
            check("bp_valid", bus1.out_valid, 1);
            check("bp_counts0", bus1.counts[0], 3);
            check("bp_busy", bus1.busy, 1);
        end
        bus1.out_ready = 1; bus1.start = 1;
        @(negedge clk);
        bus1.out_ready = 0; bus1.start = 0;
        check("bp_release_busy", bus1.busy, 0);
        check("bp_release_valid", bus1.out_valid, 0);
        @(negedge clk);
        check("bp_no_restart", bus1.busy, 0);
        check("bp_hold_counts0", bus1.counts[0], 3);

        // Abort in the fourth cycle of a 10-cycle window.
        bus1.start = 1; bus1.window_len = 10;
        @(negedge clk);
        bus1.start = 0; bus1.spike_in[0] = 1;
        repeat (3) @(negedge clk);
        bus1.abort = 1;
        @(negedge clk);
        bus1.abort = 0;
        clear_spikes1();
        check("abort_busy", bus1.busy, 0);
        check("abort_valid", bus1.out_valid, 0);
        check("abort_counts0", bus1.counts[0], 0);
        repeat (12) @(negedge clk);
        check("abort_stays_idle", bus1.out_valid, 0);

        // Abort in RESULT together with out_ready: abort clears counts.
        bus1.start = 1; bus1.window_len = 2;
        @(negedge clk);
        bus1.start = 0; bus1.spike_in[1] = 1;
        repeat (2) @(negedge clk);
        clear_spikes1();
        wait_valid1(2, 12, cyc);
        check("abres_latency", cyc, 3);
        bus1.abort = 1; bus1.out_ready = 1;
        @(negedge clk);
        bus1.abort = 0; bus1.out_ready = 0;
        check("abres_busy", bus1.busy, 0);
        check("abres_valid", bus1.out_valid, 0);
        check("abres_counts1", bus1.counts[1], 0);

        // Asynchronous reset mid-window.
        bus1.start = 1; bus1.window_len = 10;
        @(negedge clk);
        bus1.start = 0; bus1.spike_in[2] = 1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", bus1.busy, 0);
        check("arst_valid", bus1.out_valid, 0);
        check("arst_counts2", bus1.counts[2], 0);
        #1 rst = 1'b0;
        clear_spikes1();
        @(negedge clk);
        check("arst_idle", bus1.busy, 0);

        // First window after reset: zero length behaves as one cycle.
        v = '{0, 0, 1, 0, 0, 1, 0, 1, 0};
        run_vec(v);

        // Saturation on the 4-bit instance.
        bus2.start = 1; bus2.window_len = 20;
        @(negedge clk);
        bus2.start = 0; bus2.spike_in[0] = 1;
        repeat (20) @(negedge clk);
        bus2.spike_in[0] = 0;
        cyc = 20;
        while (!bus2.out_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_latency", cyc, 21);
        check("sat_counts0", bus2.counts[0], 15);
        check("sat_flag", bus2.saturated, 1);
        check("sat_winner", bus2.winner, 0);
        check("sat_tie", bus2.tie, 0);
        bus2.out_ready = 1;
        @(negedge clk);
        bus2.out_ready = 0;
        check("sat_sticky_idle", bus2.saturated, 1);
        bus2.start = 1; bus2.window_len = 3;
        @(negedge clk);
        bus2.start = 0;
        repeat (3) @(negedge clk);
        cyc = 3;
        while (!bus2.out_valid && cyc < 13) begin
            @(negedge clk);
            cyc++;
        end
        check("sat2_latency", cyc, 4);
        check("sat2_flag", bus2.saturated, 0);
        check("sat2_counts0", bus2.counts[0], 0);
        check("sat2_tie", bus2.tie, 1);
        bus2.out_ready = 1;
        @(negedge clk);
        bus2.out_ready = 0;

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
